// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding valid/ready request to
// instruction memory, instruction register with decode slices, redirect handling.
module instr_fetch #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct_3,
    output logic [6:0]      funct_7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            if_valid_n;
    logic [XLEN-1:0] if_pc_n;
    logic [XLEN-1:0] if_instr_n;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_valid <= if_valid_n;
            if_pc    <= if_pc_n;
            if_instr <= if_instr_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        if_valid_n = if_valid;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
        case (state)
            S_IDLE: state_n = S_REQ;
            // A request accepted in the redirect cycle still owes a response: drain it.
            S_REQ: begin
                if (imem_req_ready) state_n = redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_n = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_n    = S_HOLD;
                    if_valid_n = 1'b1;
                    if_pc_n    = pc;
                    if_instr_n = imem_rsp_data;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_n = S_REQ;
                end else if (!stall) begin
                    state_n    = S_REQ;
                    pc_n       = pc + XLEN'(4);
                    if_valid_n = 1'b0;
                    if_instr_n = NOP_INSTR;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) state_n = S_REQ;
            end
            default: state_n = S_IDLE;
        endcase
        // Redirect overrides stall and any capture made above.
        if (redirect_valid) begin
            pc_n       = redir_pc;
            if_valid_n = 1'b0;
            if_instr_n = NOP_INSTR;
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;

    assign opcode  = if_instr[6:0];
    assign rd      = if_instr[11:7];
    assign funct_3 = if_instr[14:12];
    assign rs1     = if_instr[19:15];
    assign rs2     = if_instr[24:20];
    assign funct_7 = if_instr[31:25];

    // A response with nothing outstanding is a memory-side protocol error.
    rsp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (state == S_WAIT || state == S_DRAIN)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scenario-driven bench for instr_fetch: expected (pc, instr) pairs are queued when
// a response is driven and compared when the fetch stage presents the instruction.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct_3;
    logic [6:0]  funct_7;
    logic [4:0]  rd, rs1, rs2;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    instr_fetch #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .opcode(opcode),
        .funct_3(funct_3),
        .funct_7(funct_7),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, lets it sit unready for ready_delay cycles,
    // accepts it, answers next cycle and queues the expected output.
    task automatic serve(input logic [31:0] exp_pc, input logic [31:0] instr,
                         input int unsigned ready_delay,
                         output logic [31:0] addr, output bit ok);
        int unsigned n = 0;
        ok = 1'b1;
        addr = '0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        addr = imem_addr;
        for (int unsigned i = 0; i < ready_delay; i++) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr;
        exp_q.push_back('{exp_pc, instr});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b req=%b instr=%h pc=%h, want 0 0 %h 0",
                     if_valid, imem_req_valid, if_instr, if_pc, NOP);
        end
        total++;
        if (opcode !== 7'h13 || rd !== 5'd0 || funct_3 !== 3'd0) begin
            bad++;
            $display("FAIL reset_fields: got opcode=%h rd=%0d f3=%0d, want 13 0 0", opcode, rd, funct_3);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        rst = 1'b0;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL t1_first_req: got req=%b addr=%h, want 1 00000000", imem_req_valid, imem_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL t1_wait: got req=%b valid=%b, want 0 0", imem_req_valid, if_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        exp_q.push_back('{32'h0, 32'h0050_0093});
        tick();
        imem_rsp_valid = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t1_out: got valid=%b pc=%h instr=%h, want 1 %h %h", if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        total++;
        if (opcode !== 7'h13 || rd !== 5'd1 || rs1 !== 5'd0 || funct_3 !== 3'd0 || rs2 !== 5'd5) begin
            bad++;
            $display("FAIL t1_fields: got opcode=%h rd=%0d rs1=%0d f3=%0d rs2=%0d, want 13 1 0 0 5",
                     opcode, rd, rs1, funct_3, rs2);
        end
    endtask

    task automatic test_ready_stall();
        logic [31:0] a;
        bit ok;
        exp_t e;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
                bad++;
                $display("FAIL t2_hold_req: cycle %0d got req=%b addr=%h, want 1 00000004", i, imem_req_valid, imem_addr);
            end
            tick();
        end
        serve(32'h4, 32'h0020_8133, 0, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || a !== 32'h4 || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t2_out: got ok=%b addr=%h valid=%b pc=%h instr=%h, want 1 00000004 1 %h %h",
                     ok, a, if_valid, if_pc, if_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        bit ok;
        exp_t e;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0020_8133 || imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL t3_stall_hold: cycle %0d got valid=%b pc=%h instr=%h req=%b, want 1 00000004 00208133 0",
                         i, if_valid, if_pc, if_instr, imem_req_valid);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0 || if_instr !== NOP) begin
            bad++;
            $display("FAIL t3_next_req: got req=%b addr=%h valid=%b instr=%h, want 1 00000008 0 %h",
                     imem_req_valid, imem_addr, if_valid, if_instr, NOP);
        end
        serve(32'h8, 32'h4000_0033, 1, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t3_out: got ok=%b valid=%b pc=%h instr=%h, want 1 1 %h %h", ok, if_valid, if_pc, if_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a;
        bit ok;
        exp_t e;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL t4_drain: got req=%b valid=%b, want 0 0", imem_req_valid, if_valid);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40 || if_instr !== NOP) begin
            bad++;
            $display("FAIL t4_dropped: got valid=%b req=%b addr=%h instr=%h, want 0 1 00000040 %h",
                     if_valid, imem_req_valid, imem_addr, if_instr, NOP);
        end
        serve(32'h40, 32'h0000_0513, 0, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t4_out: got ok=%b valid=%b pc=%h instr=%h, want 1 1 %h %h", ok, if_valid, if_pc, if_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_redirect_rsp();
        logic [31:0] a;
        bit ok;
        exp_t e;
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin
            bad++;
            $display("FAIL t5_req44: got req=%b addr=%h, want 1 00000044", imem_req_valid, imem_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h83;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h80) begin
            bad++;
            $display("FAIL t5_same_cycle: got valid=%b req=%b addr=%h, want 0 1 00000080", if_valid, imem_req_valid, imem_addr);
        end
        serve(32'h80, 32'h00C5_8593, 0, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t5_out: got ok=%b valid=%b pc=%h instr=%h, want 1 1 %h %h", ok, if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        total++;
        if (if_valid !== 1'b0 || if_instr !== NOP || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL t5_stall_redirect: got valid=%b instr=%h req=%b addr=%h, want 0 %h 1 00000100",
                     if_valid, if_instr, imem_req_valid, imem_addr, NOP);
        end
        // accepted request in the same cycle as a redirect must be drained
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL t5_req_redirect_drain: got req=%b, want 0", imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();
        imem_rsp_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL t5_after_drain: got req=%b addr=%h valid=%b, want 1 00000200 0", imem_req_valid, imem_addr, if_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, instr, pc_m;
        bit ok;
        exp_t e;
        pc_m = 32'h200;
        for (int i = 0; i < 6; i++) begin
            instr = $urandom;
            serve(pc_m, instr, $urandom_range(0, 2), a, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || a !== pc_m || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
                bad++;
                $display("FAIL b2b_out[%0d]: got ok=%b addr=%h valid=%b pc=%h instr=%h, want 1 %h 1 %h %h",
                         i, ok, a, if_valid, if_pc, if_instr, pc_m, e.pc, e.instr);
            end
            total++;
            if (opcode !== e.instr[6:0] || rd !== e.instr[11:7] || funct_3 !== e.instr[14:12] ||
                rs1 !== e.instr[19:15] || rs2 !== e.instr[24:20] || funct_7 !== e.instr[31:25]) begin
                bad++;
                $display("FAIL b2b_fields[%0d]: got op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h for instr %h",
                         i, opcode, rd, funct_3, rs1, rs2, funct_7, e.instr);
            end
            pc_m = pc_m + 32'd4;
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] a;
        bit ok;
        exp_t e;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL t6_align: got req=%b addr=%h, want 1 fffffffc", imem_req_valid, imem_addr);
        end
        serve(32'hFFFF_FFFC, 32'h0000_006F, 0, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL t6_top_out: got ok=%b valid=%b pc=%h instr=%h, want 1 1 %h %h", ok, if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        tick();
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL t6_wrap: got req=%b addr=%h, want 1 00000000", imem_req_valid, imem_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin
            bad++;
            $display("FAIL t6_async_reset: got valid=%b req=%b instr=%h pc=%h, want 0 0 %h 00000000",
                     if_valid, imem_req_valid, if_instr, if_pc, NOP);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFEED_FACE;
        tick();
        imem_rsp_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL t6_after_reset: got valid=%b req=%b addr=%h, want 0 1 00000000", if_valid, imem_req_valid, imem_addr);
        end
        serve(32'h0, 32'h0010_0113, 0, a, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr || exp_q.size() != 0) begin
            bad++;
            $display("FAIL t6_refetch: got ok=%b valid=%b pc=%h instr=%h qsize=%0d, want 1 1 %h %h 0",
                     ok, if_valid, if_pc, if_instr, exp_q.size(), e.pc, e.instr);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_ready_stall();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_back_to_back();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
